// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss refill sequencer: line read, bank-wide data writes, tag write.
// Optional whole-cache tag invalidation sweep is built when ICACHE_REFILL_FLUSH_EN is defined.
module icache_refill_ctrl #(
  parameter int PLEN       = 32,
  parameter int LINE_WIDTH = 512,
  parameter int SET_ASSOC  = 4,
  parameter int NUM_SETS   = 16,
  parameter int NUM_BANKS  = 4,
  parameter int MEM_DW     = 64,
  localparam int INDEX_W   = $clog2(NUM_SETS),
  localparam int WAY_W     = $clog2(SET_ASSOC),
  localparam int BSEL_W    = $clog2(NUM_BANKS),
  localparam int BANK_W    = LINE_WIDTH / NUM_BANKS,
  localparam int BEATS     = LINE_WIDTH / MEM_DW,
  localparam int BEAT_W    = $clog2(BEATS),
  localparam int OFF_W     = $clog2(LINE_WIDTH / 8),
  localparam int TAG_W     = PLEN - INDEX_W - OFF_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 miss_valid_i,
  output logic                 miss_ready_o,
  input  logic [PLEN-1:0]      miss_paddr_i,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic [PLEN-1:0]      mem_req_addr_o,
  input  logic                 mem_rsp_valid_i,
  input  logic [MEM_DW-1:0]    mem_rsp_data_i,
  input  logic                 mem_rsp_err_i,
  output logic                 data_we_o,
  output logic [WAY_W-1:0]     data_way_o,
  output logic [INDEX_W-1:0]   data_index_o,
  output logic [BSEL_W-1:0]    data_bank_o,
  output logic [BANK_W-1:0]    data_wdata_o,
  output logic                 tag_we_o,
  output logic [SET_ASSOC-1:0] tag_way_mask_o,
  output logic [INDEX_W-1:0]   tag_index_o,
  output logic [TAG_W-1:0]     tag_wdata_o,
  output logic                 tag_valid_o,
  output logic                 refill_done_o,
  output logic                 refill_err_o,
  input  logic                 flush_i,
  output logic                 flush_done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RECV,
    S_TAG_WR
`ifdef ICACHE_REFILL_FLUSH_EN
    , S_FLUSH
`endif
  } state_e;

  state_e                  state_q, state_d;
  logic [PLEN-OFF_W-1:0]   line_q, line_d;
  logic [WAY_W-1:0]        way_q, way_d;
  logic [WAY_W-1:0]        rr_q, rr_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic                    err_q, err_d;
  logic [MEM_DW-1:0]       low_q, low_d;

`ifdef ICACHE_REFILL_FLUSH_EN
  logic                    fpend_q, fpend_d;
  logic [INDEX_W-1:0]      fidx_q, fidx_d;
  logic                    flush_go;
`else
  logic                    unused_flush;
  assign unused_flush = flush_i;
`endif

  // Byte offset within the line never reaches memory or the tag array.
  logic [OFF_W-1:0]        unused_off;
  assign unused_off = miss_paddr_i[OFF_W-1:0];

  assign mem_req_addr_o = {line_q, {OFF_W{1'b0}}};
  assign data_way_o     = way_q;
  assign data_index_o   = line_q[INDEX_W-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      way_q   <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      low_q   <= '0;
`ifdef ICACHE_REFILL_FLUSH_EN
      fpend_q <= 1'b0;
      fidx_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      way_q   <= way_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      low_q   <= low_d;
`ifdef ICACHE_REFILL_FLUSH_EN
      fpend_q <= fpend_d;
      fidx_q  <= fidx_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    way_d   = way_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    err_d   = err_q;
    low_d   = low_q;
`ifdef ICACHE_REFILL_FLUSH_EN
    fpend_d  = fpend_q;
    fidx_d   = fidx_q;
    flush_go = flush_i || fpend_q;
`endif

    miss_ready_o    = 1'b0;
    mem_req_valid_o = 1'b0;
    data_we_o       = 1'b0;
    data_bank_o     = '0;
    data_wdata_o    = '0;
    tag_we_o        = 1'b0;
    tag_way_mask_o  = '0;
    tag_index_o     = '0;
    tag_wdata_o     = '0;
    tag_valid_o     = 1'b0;
    refill_done_o   = 1'b0;
    refill_err_o    = 1'b0;
    flush_done_o    = 1'b0;

`ifdef ICACHE_REFILL_FLUSH_EN
    // A flush arriving mid-refill waits; the refill always runs to completion.
    if (flush_i && (state_q != S_IDLE) && (state_q != S_FLUSH)) fpend_d = 1'b1;
`endif

    case (state_q)
      S_IDLE: begin
`ifdef ICACHE_REFILL_FLUSH_EN
        if (flush_go) state_d = S_FLUSH;
        else
`endif
        begin
          miss_ready_o = 1'b1;
          if (miss_valid_i) begin
            line_d  = miss_paddr_i[PLEN-1:OFF_W];
            way_d   = rr_q;
            state_d = S_REQ;
          end
        end
      end

      S_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) begin
          beat_d  = '0;
          state_d = S_RECV;
        end
      end

      S_RECV: begin
        if (mem_rsp_valid_i) begin
          beat_d = beat_q + BEAT_W'(1);
          if (mem_rsp_err_i) err_d = 1'b1;
          // Two beats per bank word: hold the even beat, write on the odd one.
          if (!beat_q[0]) begin
            low_d = mem_rsp_data_i;
          end else begin
            data_we_o    = 1'b1;
            data_bank_o  = BSEL_W'(beat_q >> 1);
            data_wdata_o = BANK_W'({mem_rsp_data_i, low_q});
          end
          if (beat_q == BEAT_W'(BEATS - 1)) state_d = S_TAG_WR;
        end
      end

      S_TAG_WR: begin
        tag_we_o       = 1'b1;
        tag_way_mask_o = SET_ASSOC'(1) << way_q;
        tag_index_o    = line_q[INDEX_W-1:0];
        tag_wdata_o    = line_q[PLEN-OFF_W-1:INDEX_W];
        tag_valid_o    = !err_q;
        refill_done_o  = 1'b1;
        refill_err_o   = err_q;
        // An errored line is left invalid, so its way is reused by the next miss.
        if (!err_q) rr_d = (rr_q == WAY_W'(SET_ASSOC - 1)) ? '0 : rr_q + WAY_W'(1);
        err_d = 1'b0;
`ifdef ICACHE_REFILL_FLUSH_EN
        state_d = (fpend_q || flush_i) ? S_FLUSH : S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end

`ifdef ICACHE_REFILL_FLUSH_EN
      S_FLUSH: begin
        tag_we_o       = 1'b1;
        tag_way_mask_o = '1;
        tag_index_o    = fidx_q;
        tag_valid_o    = 1'b0;
        fidx_d         = fidx_q + INDEX_W'(1);
        if (fidx_q == INDEX_W'(NUM_SETS - 1)) begin
          flush_done_o = 1'b1;
          rr_d         = '0;
          fpend_d      = 1'b0;
          fidx_d       = '0;
          state_d      = S_IDLE;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

endmodule
